// File: rtl/titan_bus_pkg.sv
// Shared instruction-bus opcodes and word/address types for the per-core stream buffers.
package titan_bus_pkg;

  localparam logic [7:0] OP_STREAM_READ  = 8'h10;
  localparam logic [7:0] OP_STREAM_FLUSH = 8'h11;
  localparam logic [7:0] OP_STREAM_COUNT = 8'h12;

  typedef logic [31:0] bus_word_t;
  typedef logic [23:0] bus_addr_t;

endpackage

// File: rtl/stream_buffer_if.sv
// Core-side push handshake plus instruction-bus command and readback signals of one stream buffer.
interface stream_buffer_if #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 24
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] core_data_i;
  logic              core_valid_i;
  logic              core_ready_o;
  logic [7:0]        instruction_i;
  logic [ADDR_W-1:0] address_i;
  logic              instr_valid_i;
  logic [DATA_W-1:0] stream_o;
  logic [DATA_W-1:0] result_o;
  logic [CNT_W-1:0]  count_o;
  logic              empty_o;
  logic              underflow_o;

  modport slave (
    input  core_data_i, core_valid_i, instruction_i, address_i, instr_valid_i,
    output core_ready_o, stream_o, result_o, count_o, empty_o, underflow_o
  );

  modport master (
    output core_data_i, core_valid_i, instruction_i, address_i, instr_valid_i,
    input  core_ready_o, stream_o, result_o, count_o, empty_o, underflow_o
  );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO storage with wrapping pointers and a separately tracked occupancy count.
module sync_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic                         flush_i,
  input  logic [DATA_W-1:0]            wdata_i,
  output logic [DATA_W-1:0]            rdata_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         full_o,
  output logic                         empty_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;

  assign rdata_o = mem[rd_ptr];
  assign count_o = count;
  assign full_o  = (count == CNT_W'(DEPTH));
  assign empty_o = (count == '0);

  // Storage needs no reset; only pointers and count define which entries are live.
  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) begin
      mem[wr_ptr] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_i) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_i) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_i, pop_i})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/stream_buffer.sv
// Per-core output FIFO: the core pushes words, the instruction bus pops, flushes and reads the fill level.
module stream_buffer
  import titan_bus_pkg::*;
#(
  parameter int              DATA_W    = 32,
  parameter int              DEPTH     = 16,
  parameter int              ADDR_W    = 24,
  parameter logic [ADDR_W-1:0] CORE_ADDR = ADDR_W'(24'h000001)
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  stream_buffer_if.slave bus
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              cmd;
  logic              rd_cmd;
  logic              flush_cmd;
  logic              count_cmd;
  logic              push;
  logic              pop;
  logic              full;
  logic              empty;
  logic [DATA_W-1:0] head;
  logic [CNT_W-1:0]  count;

  assign cmd       = bus.instr_valid_i && (bus.address_i == CORE_ADDR);
  assign rd_cmd    = cmd && (bus.instruction_i == OP_STREAM_READ);
  assign flush_cmd = cmd && (bus.instruction_i == OP_STREAM_FLUSH);
  assign count_cmd = cmd && (bus.instruction_i == OP_STREAM_COUNT);

  // Ready never looks at core_valid_i, and a flush blocks the push it would otherwise discard.
  assign bus.core_ready_o = !full && !flush_cmd;
  assign push             = bus.core_valid_i && bus.core_ready_o;
  assign pop              = rd_cmd && !empty;

  assign bus.count_o = count;
  assign bus.empty_o = empty;

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (flush_cmd),
    .wdata_i (bus.core_data_i),
    .rdata_o (head),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );

  // A READ on an empty buffer returns zero and latches underflow until the next flush.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bus.stream_o    <= '0;
      bus.result_o    <= '0;
      bus.underflow_o <= 1'b0;
    end else begin
      if (rd_cmd) begin
        bus.stream_o <= empty ? '0 : head;
      end
      if (count_cmd) begin
        bus.result_o <= DATA_W'(count);
      end
      if (flush_cmd) begin
        bus.underflow_o <= 1'b0;
      end else if (rd_cmd && empty) begin
        bus.underflow_o <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_stream_buffer.sv
// Randomized and directed bench for stream_buffer against a queue-based behavioural model.
module tb_stream_buffer;
  import titan_bus_pkg::*;

  localparam int        DATA_W    = 32;
  localparam int        DEPTH     = 16;
  localparam int        ADDR_W    = 24;
  localparam bus_addr_t CORE_ADDR = 24'h000001;
  localparam bus_addr_t OTHER_ADDR = 24'h000002;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  stream_buffer_if #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) bus ();

  stream_buffer #(
    .DATA_W    (DATA_W),
    .DEPTH     (DEPTH),
    .ADDR_W    (ADDR_W),
    .CORE_ADDR (CORE_ADDR)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  // Model state: the queue holds exactly the words the buffer should contain, oldest first.
  bus_word_t model_q[$];
  bus_word_t m_stream;
  bus_word_t m_result;
  logic      m_uf;

  task automatic compare(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic model_ready();
    logic flush_now;
    flush_now = bus.instr_valid_i && (bus.address_i == CORE_ADDR) &&
                (bus.instruction_i == OP_STREAM_FLUSH);
    return (model_q.size() < DEPTH) && !flush_now;
  endfunction

  task automatic modelReset();
    model_q.delete();
    m_stream = '0;
    m_result = '0;
    m_uf     = 1'b0;
  endtask

  // Applies one clock edge of behaviour using the inputs that were stable before the edge.
  task automatic modelStep();
    logic cmd;
    logic push;
    int   old_count;
    cmd       = bus.instr_valid_i && (bus.address_i == CORE_ADDR);
    push      = bus.core_valid_i && model_ready();
    old_count = model_q.size();
    if (cmd && bus.instruction_i == OP_STREAM_READ) begin
      if (old_count == 0) begin
        m_stream = '0;
        m_uf     = 1'b1;
      end else begin
        m_stream = model_q.pop_front();
      end
    end
    if (cmd && bus.instruction_i == OP_STREAM_FLUSH) begin
      model_q.delete();
      m_uf = 1'b0;
    end
    if (cmd && bus.instruction_i == OP_STREAM_COUNT) begin
      m_result = 32'(old_count);
    end
    if (push) begin
      model_q.push_back(bus.core_data_i);
    end
  endtask

  task automatic checkOutput();
    compare("stream_o",    bus.stream_o, m_stream);
    compare("result_o",    bus.result_o, m_result);
    compare("count_o",     32'(bus.count_o), 32'(model_q.size()));
    compare("empty_o",     32'(bus.empty_o), 32'(model_q.size() == 0));
    compare("underflow_o", 32'(bus.underflow_o), 32'(m_uf));
  endtask

  // One full cycle: drive at the falling edge, check ready, model the edge, check registers.
  task automatic applyStimulus(input logic valid, input bus_word_t data, input logic iv,
                               input logic [7:0] op, input bus_addr_t addr);
    bus.core_valid_i  = valid;
    bus.core_data_i   = data;
    bus.instr_valid_i = iv;
    bus.instruction_i = op;
    bus.address_i     = addr;
    #1;
    compare("core_ready_o", 32'(bus.core_ready_o), 32'(model_ready()));
    @(posedge clk);
    modelStep();
    @(negedge clk);
    checkOutput();
  endtask

  task automatic idle();
    applyStimulus(1'b0, '0, 1'b0, 8'h00, '0);
  endtask

  task automatic pushWord(input bus_word_t data);
    applyStimulus(1'b1, data, 1'b0, 8'h00, '0);
  endtask

  task automatic command(input logic [7:0] op, input bus_addr_t addr);
    applyStimulus(1'b0, '0, 1'b1, op, addr);
  endtask

  task automatic doReset();
    bus.core_valid_i  = 1'b0;
    bus.core_data_i   = '0;
    bus.instr_valid_i = 1'b0;
    bus.instruction_i = 8'h00;
    bus.address_i     = '0;
    #2;
    rst_n = 1'b0;
    modelReset();
    #1;
    checkOutput();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput();
    compare("ready_after_reset", 32'(bus.core_ready_o), 32'd1);
    @(negedge clk);
  endtask

  initial begin
    int pushed;
    int guard;
    int r;
    logic [7:0] op;
    modelReset();
    @(negedge clk);

    // Test 1: reset
    doReset();
    compare("rst_count_lit",  32'(bus.count_o), 32'd0);
    compare("rst_empty_lit",  32'(bus.empty_o), 32'd1);
    compare("rst_stream_lit", bus.stream_o, 32'd0);

    // Test 2: in-order pops with one-cycle latency
    for (int i = 1; i <= 3; i++) pushWord(32'hA5A5_0000 + 32'(i));
    for (int i = 1; i <= 3; i++) begin
      command(OP_STREAM_READ, CORE_ADDR);
      compare("pop_order_lit", bus.stream_o, 32'hA5A5_0000 + 32'(i));
    end
    compare("drained_empty_lit", 32'(bus.empty_o), 32'd1);

    // Test 3: full, hold-off, pop with concurrent valid
    for (int i = 0; i < DEPTH; i++) pushWord($urandom);
    compare("full_count_lit", 32'(bus.count_o), 32'd16);
    compare("full_ready_lit", 32'(bus.core_ready_o), 32'd0);
    pushWord(32'hDEAD_0017);
    applyStimulus(1'b1, 32'hDEAD_0017, 1'b1, OP_STREAM_READ, CORE_ADDR);
    pushWord(32'hDEAD_0017);
    compare("refill_count_lit", 32'(bus.count_o), 32'd16);
    guard = 0;
    while (model_q.size() > 0 && guard < 2 * DEPTH) begin
      command(OP_STREAM_READ, CORE_ADDR);
      guard++;
    end
    compare("last_word_lit", bus.stream_o, 32'hDEAD_0017);

    // Test 4: underflow then flush
    command(OP_STREAM_READ, CORE_ADDR);
    compare("uf_stream_lit", bus.stream_o, 32'd0);
    compare("uf_flag_lit",   32'(bus.underflow_o), 32'd1);
    command(OP_STREAM_FLUSH, CORE_ADDR);
    compare("flush_uf_lit",  32'(bus.underflow_o), 32'd0);

    // Test 5: count readback, foreign address, flush with push
    for (int i = 0; i < 5; i++) pushWord($urandom);
    command(OP_STREAM_COUNT, CORE_ADDR);
    compare("count_result_lit", bus.result_o, 32'd5);
    command(OP_STREAM_READ, OTHER_ADDR);
    applyStimulus(1'b1, 32'h1234_5678, 1'b1, OP_STREAM_FLUSH, CORE_ADDR);
    compare("flush_count_lit", 32'(bus.count_o), 32'd0);

    // Test 6: push 20 words while popping every other cycle, then drain across the wrap
    pushed = 0;
    for (int i = 0; pushed < 20 && i < 100; i++) begin
      applyStimulus(1'b1, $urandom, i[0], OP_STREAM_READ, CORE_ADDR);
      pushed++;
    end
    guard = 0;
    while (model_q.size() > 0 && guard < 2 * DEPTH) begin
      command(OP_STREAM_READ, CORE_ADDR);
      guard++;
    end

    // Reset while holding data discards everything at once
    for (int i = 0; i < 3; i++) pushWord($urandom);
    doReset();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 9);
      if (r < 5)      op = OP_STREAM_READ;
      else if (r == 5) op = OP_STREAM_FLUSH;
      else if (r < 8) op = OP_STREAM_COUNT;
      else            op = 8'h13;
      applyStimulus($urandom_range(0, 2) != 0, $urandom, $urandom_range(0, 1) == 1, op,
                    ($urandom_range(0, 3) == 0) ? OTHER_ADDR : CORE_ADDR);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
